// File: rtl/abus_arbiter.sv
// abus_arbiter: round-robin owner selection for one shared abus segment.
// One grant at a time, a mandatory one-cycle turnaround after every grant,
// and an optional watchdog that revokes a grant nobody acknowledges.

// Per-master slice: decodes its own grant bit from the winner index and
// steers the shared slave acknowledge back only when it owns the bus.
module abus_arb_lane #(
  parameter logic [2:0] IDX = 3'd0
) (
  input  logic [2:0] win_idx_i,
  input  logic       grant_i,
  input  logic       ack_i,
  output logic       hit_o,
  output logic       mack_o
);

  assign hit_o  = (win_idx_i == IDX);
  assign mack_o = grant_i & ack_i;

endmodule

module abus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   abus_clk,
  input  logic                   abus_rst,
  input  logic                   arb_en,
  input  logic [NUM_MASTERS-1:0] abus_mreq,
  input  logic                   abus_ack,
  output logic [NUM_MASTERS-1:0] abus_mgrant,
  output logic [NUM_MASTERS-1:0] abus_mack,
  output logic [2:0]             abus_mid,
  output logic                   busy,
  output logic                   timeout,
  output logic [2:0]             timeout_mid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Watchdog counter is wide enough to hold TIMEOUT_CYCLES; a zero
  // timeout keeps a single always-zero bit.
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_EXP = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [2:0]    RR_RST  = 3'(NUM_MASTERS - 1);

  logic [1:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [2:0]             mid_q, mid_d;
  logic [2:0]             rr_q, rr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   to_q, to_d;
  logic [2:0]             tmid_q, tmid_d;

  logic [7:0]             req_ext;
  logic                   owner_req;
  logic                   win_found;
  logic [2:0]             win_idx;
  logic [2:0]             cand;
  logic [NUM_MASTERS-1:0] win_onehot;
  logic                   expire;

  // Zero-extend requests to the full 3-bit index space so the owner lookup
  // by abus_mid never selects outside the vector.
  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_MASTERS-1:0] = abus_mreq;
  end

  assign owner_req = req_ext[mid_q];

  // Rotating search starting one past the last owner, wrapping in index order.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = 3'((int'(rr_q) + k) % NUM_MASTERS);
      if (!win_found && req_ext[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // One lane per master: grant decode and acknowledge gating.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_lane
      abus_arb_lane #(.IDX(3'(gi))) u_lane (
        .win_idx_i (win_idx),
        .grant_i   (grant_q[gi]),
        .ack_i     (abus_ack),
        .hit_o     (win_onehot[gi]),
        .mack_o    (abus_mack[gi])
      );
    end
  endgenerate

  // Ack in the same cycle as the final count rescues the grant.
  assign expire = TO_EN && !abus_ack && (cnt_q == CNT_EXP);

  // Next-state logic: arbitration in IDLE, release/watchdog in OWN,
  // unconditional single turnaround cycle in GAP.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    mid_d   = mid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    tmid_d  = tmid_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (arb_en && win_found) begin
          state_d = S_OWN;
          grant_d = win_onehot;
          mid_d   = win_idx;
          rr_d    = win_idx;
        end
      end
      S_OWN: begin
        if (!owner_req) begin
          // Release takes precedence over a coincident expiry.
          state_d = S_GAP;
          grant_d = '0;
          cnt_d   = '0;
        end else if (expire) begin
          state_d = S_GAP;
          grant_d = '0;
          cnt_d   = '0;
          to_d    = 1'b1;
          tmid_d  = mid_q;
        end else if (!TO_EN || abus_ack) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; synchronous reset overrides everything, even mid-grant.
  always_ff @(posedge abus_clk) begin
    if (abus_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      mid_q   <= '0;
      rr_q    <= RR_RST;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      tmid_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      mid_q   <= mid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      tmid_q  <= tmid_d;
    end
  end

  assign abus_mgrant = grant_q;
  assign abus_mid    = mid_q;
  assign busy        = (state_q == S_OWN);
  assign timeout     = to_q;
  assign timeout_mid = tmid_q;

endmodule

// File: tb/tb_abus_arbiter.sv
// Bench for abus_arbiter: directed scenarios plus randomized traffic,
// scored against a transaction-level model of the arbitration rules.
module tb_abus_arbiter;

  localparam int NM = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [NM-1:0] mreq = '0;
  logic          ack = 1'b0;
  logic [NM-1:0] mgrant, mack;
  logic [2:0]    mid, tmid;
  logic          busy, tout;

  abus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .abus_clk    (clk),
    .abus_rst    (rst),
    .arb_en      (en),
    .abus_mreq   (mreq),
    .abus_ack    (ack),
    .abus_mgrant (mgrant),
    .abus_mack   (mack),
    .abus_mid    (mid),
    .busy        (busy),
    .timeout     (tout),
    .timeout_mid (tmid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NM-1:0] g;
    logic [2:0]    mid;
    logic          busy;
    logic          to;
    logic [2:0]    tmid;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_to   = 0;

  // Model: who owns the bus, how many cycles remain before arbitration
  // may happen again, and how many un-acked cycles the owner has used.
  int m_owner, m_mid, m_rr, m_hold, m_cnt, m_tmid, m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input logic [NM-1:0] rq, input bit a);
    bit found;
    if (r) begin
      m_owner = -1; m_mid = 0; m_rr = NM - 1; m_hold = 0;
      m_cnt = 0; m_tmid = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (m_owner >= 0) begin
      if (!rq[2'(m_owner)]) begin
        m_owner = -1; m_hold = 1;
      end else if (a) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_to = 1; m_tmid = m_owner; m_owner = -1; m_hold = 1;
        end
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (e) begin
      found = 0;
      for (int k = 1; k <= NM; k++) begin
        int i;
        i = (m_rr + k) % NM;
        if (!found && rq[2'(i)]) begin
          found = 1; m_owner = i; m_mid = i; m_rr = i; m_cnt = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue what the DUT must
  // show after the coming edge.
  task automatic step(input bit r, input bit e, input logic [NM-1:0] rq, input bit a);
    exp_t x;
    #1;
    rst = r; en = e; mreq = rq; ack = a;
    model_edge(r, e, rq, a);
    x.g    = (m_owner >= 0) ? NM'(1 << m_owner) : '0;
    x.mid  = 3'(m_mid);
    x.busy = (m_owner >= 0);
    x.to   = m_to[0];
    x.tmid = 3'(m_tmid);
    if (m_to != 0) n_to++;
    @(posedge clk);
    sb.push_back(x);
  endtask

  // Monitor: compare each registered response half a cycle after its edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("mgrant",      32'(mgrant), 32'(e.g));
      chk("mid",         32'(mid),    32'(e.mid));
      chk("busy",        32'(busy),   32'(e.busy));
      chk("timeout",     32'(tout),   32'(e.to));
      chk("timeout_mid", 32'(tmid),   32'(e.tmid));
      chk("mack",        32'(mack),   32'(e.g & {NM{ack}}));
    end
  end

  initial begin
    logic [NM-1:0] rq;
    int ack_pct;
    @(posedge clk);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);

    // Single requester: grant, ack, release, turnaround.
    step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0001, 1);
    step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b0000, 0);

    // All requesting; owner drops its bit for one cycle after being acked.
    for (int c = 0; c < 40; c++) begin
      rq = 4'b1111;
      if (m_owner >= 0 && m_cnt == 0 && ack) rq[2'(m_owner)] = 1'b0;
      step(0, 1, rq, (c % 3) == 1);
    end

    // Owner 2 with 0 and 3 waiting: 3 must follow 2.
    step(1, 0, '0, 0);
    step(0, 1, 4'b0110, 0);   // master 1 wins first (rr starts at 3)
    step(0, 1, 4'b0100, 1);   // master 1 releases
    for (int c = 0; c < 3; c++) step(0, 1, 4'b0100, 0);
    for (int c = 0; c < 4; c++) step(0, 1, 4'b1101, 1);
    for (int c = 0; c < 6; c++) step(0, 1, 4'b1001, 1);

    // Watchdog: master 1 never acked, times out, then regranted alone.
    step(1, 0, '0, 0);
    for (int c = 0; c < 16; c++) step(0, 1, 4'b0010, 0);
    // Ack every 5 cycles keeps the grant alive.
    for (int c = 0; c < 100; c++) step(0, 1, 4'b0010, (c % 5) == 0);

    // arb_en low: current owner finishes, no new grant until re-enabled.
    step(1, 0, '0, 0);
    step(0, 1, 4'b0001, 1);
    for (int c = 0; c < 3; c++) step(0, 0, 4'b0001, 1);
    for (int c = 0; c < 5; c++) step(0, 0, 4'b0110, 0);
    step(0, 1, 4'b0110, 1);
    step(0, 1, 4'b0110, 1);
    // Reset in the middle of ownership.
    step(1, 1, 4'b0110, 1);
    step(0, 1, 4'b0000, 0);

    // Randomized traffic with varying acknowledge density.
    ack_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) ack_pct = $urandom_range(0, 3) * 30;
      for (int i = 0; i < NM; i++)
        rq[i] = (i == m_owner) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 50);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), rq,
           ($urandom_range(0, 99) < ack_pct));
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(sb.size()), 32'd0);
    if (n_to == 0) chk("timeout_exercised", 32'(n_to), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
